// File: rtl/sik_pkg.sv
// Shared constants and types for the thread fetch scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sik_pkg;

    localparam int WORD_W = 16;
    localparam int TID_W  = 1;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [TID_W-1:0]  tid_t;

    // Instruction encoding that executes as a no-op.
    localparam word_t NOOP = 16'h0000;

    // Default reset PCs and per-fetch PC increment.
    localparam word_t PC0_RST     = 16'h0000;
    localparam word_t PC1_RST     = 16'h0001;
    localparam word_t PC_STEP_DEF = 16'h0002;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin choice: prefer the thread that did not issue last.
// Latency: combinational.
// Backpressure: none; valid drops when neither thread is eligible.
module rr_pick
    import sik_pkg::*;
(
    input  logic [1:0] eligible,
    input  tid_t       last,
    output logic       valid,
    output tid_t       tid
);

    tid_t other;
    assign other = ~last;

    // Other thread first, then repeat the last one, else nothing.
    always_comb begin
        valid = 1'b0;
        tid   = last;
        if (eligible[other]) begin
            valid = 1'b1;
            tid   = other;
        end else if (eligible[last]) begin
            valid = 1'b1;
            tid   = last;
        end
    end

endmodule

// File: rtl/thread_sched.sv
// Two-thread instruction fetch scheduler with redirect and sticky halt (optional stall: SCHED_STALL_EN).
// Latency: one cycle; selection made at an edge is on the registered outputs after that edge.
// Backpressure: stall (when built in), redirect or halt on a thread removes it from issue that cycle.
module thread_sched
    import sik_pkg::*;
#(
    parameter word_t PC0_INIT = PC0_RST,
    parameter word_t PC1_INIT = PC1_RST,
    parameter word_t PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  tid_t        redirect_tid,
    input  word_t       redirect_pc,
    input  logic        halt_req,
    input  tid_t        halt_tid,
`ifdef SCHED_STALL_EN
    input  logic [1:0]  stall,
`endif
    output logic        fetch_valid,
    output tid_t        fetch_tid,
    output word_t       fetch_pc,
    output logic [1:0]  thread_halted,
    output logic        halt
);

    word_t      pc [2];
    tid_t       last_tid;
    logic [1:0] redir_hit;
    logic [1:0] halt_hit;
    logic [1:0] stall_mask;
    logic [1:0] eligible;
    logic [1:0] redir_apply;
    logic [1:0] halted_nxt;
    logic       pick_vld;
    tid_t       pick_tid;

`ifdef SCHED_STALL_EN
    assign stall_mask = stall;
`else
    assign stall_mask = 2'b00;
`endif

    // Per-thread decode of this cycle's redirect/halt events.
    always_comb begin
        redir_hit   = redirect_valid ? (2'b01 << redirect_tid) : 2'b00;
        halt_hit    = halt_req ? (2'b01 << halt_tid) : 2'b00;
        // A redirected thread sits out one cycle so no wrong-path PC is fetched.
        eligible    = ~thread_halted & ~redir_hit & ~halt_hit & ~stall_mask;
        // Halt beats a same-thread redirect; halted threads ignore redirects.
        redir_apply = redir_hit & ~halt_hit & ~thread_halted;
        halted_nxt  = thread_halted | halt_hit;
    end

    rr_pick u_rr_pick (
        .eligible (eligible),
        .last     (last_tid),
        .valid    (pick_vld),
        .tid      (pick_tid)
    );

    // Fetch output registers, per-thread PCs and sticky halt state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc[0]         <= PC0_INIT;
            pc[1]         <= PC1_INIT;
            last_tid      <= 1'b1;
            fetch_valid   <= 1'b0;
            fetch_tid     <= 1'b0;
            fetch_pc      <= '0;
            thread_halted <= 2'b00;
            halt          <= 1'b0;
        end else begin
            fetch_valid <= pick_vld;
            if (pick_vld) begin
                fetch_tid <= pick_tid;
                fetch_pc  <= pc[pick_tid];
                last_tid  <= pick_tid;
            end
            for (int i = 0; i < 2; i++) begin
                if (redir_apply[i]) begin
                    pc[i] <= redirect_pc;
                end else if (pick_vld && pick_tid == tid_t'(i)) begin
                    pc[i] <= pc[i] + PC_STEP;
                end
            end
            thread_halted <= halted_nxt;
            halt          <= &halted_nxt;
        end
    end

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: expected fetch records pushed at drive time, popped after the edge.
// Latency: expects results one clock after inputs are applied.
// Backpressure: exercises stall only when SCHED_STALL_EN is defined.
module tb_thread_sched;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic        redirect_tid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halt_tid;
`ifdef SCHED_STALL_EN
    logic [1:0]  stall;
    localparam logic [1:0] STALL_MASK = 2'b11;
`else
    localparam logic [1:0] STALL_MASK = 2'b00;
`endif
    logic        fetch_valid;
    logic        fetch_tid;
    logic [15:0] fetch_pc;
    logic [1:0]  thread_halted;
    logic        halt;

    thread_sched dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halt_tid       (halt_tid),
`ifdef SCHED_STALL_EN
        .stall          (stall),
`endif
        .fetch_valid    (fetch_valid),
        .fetch_tid      (fetch_tid),
        .fetch_pc       (fetch_pc),
        .thread_halted  (thread_halted),
        .halt           (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fv;
        logic        tid;
        logic [15:0] pc;
        logic [1:0]  hd;
        logic        h;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference state.
    logic [15:0] m_pc [2];
    logic        m_last;
    logic        m_fv;
    logic        m_tid;
    logic [15:0] m_fpc;
    logic [1:0]  m_hd;
    logic        m_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference, compare after the edge.
    task automatic cyc(input logic rst, input logic rv, input logic rt, input logic [15:0] rp,
                       input logic hr, input logic ht, input logic [1:0] st);
        exp_t       e;
        exp_t       g;
        logic [1:0] el;
        logic [1:0] st_eff;
        logic       o;
        logic       t;
        logic       issue;
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_tid   = rt;
        redirect_pc    = rp;
        halt_req       = hr;
        halt_tid       = ht;
`ifdef SCHED_STALL_EN
        stall          = st;
`endif
        st_eff = st & STALL_MASK;
        if (rst) begin
            m_pc[0] = 16'h0000;
            m_pc[1] = 16'h0001;
            m_last  = 1'b1;
            m_fv    = 1'b0;
            m_tid   = 1'b0;
            m_fpc   = 16'h0000;
            m_hd    = 2'b00;
            m_h     = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                el[i] = !m_hd[i] && !(rv && rt == i[0]) && !(hr && ht == i[0]) && !st_eff[i];
            o     = ~m_last;
            t     = m_last;
            issue = 1'b0;
            if (el[o]) begin
                t = o; issue = 1'b1;
            end else if (el[m_last]) begin
                issue = 1'b1;
            end
            m_fv = issue;
            if (issue) begin
                m_tid   = t;
                m_fpc   = m_pc[t];
                m_pc[t] = m_pc[t] + 16'd2;
                m_last  = t;
            end
            if (rv && !m_hd[rt] && !(hr && ht == rt)) m_pc[rt] = rp;
            if (hr) m_hd[ht] = 1'b1;
            m_h = m_hd[0] && m_hd[1];
        end
        e.fv = m_fv; e.tid = m_tid; e.pc = m_fpc; e.hd = m_hd; e.h = m_h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("fetch_valid",   fetch_valid,   g.fv);
        chk("fetch_tid",     fetch_tid,     g.tid);
        chk("fetch_pc",      fetch_pc,      g.pc);
        chk("thread_halted", thread_halted, g.hd);
        chk("halt",          halt,          g.h);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    endtask

    logic [15:0] seq_pc [4];

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_tid = 1'b0; redirect_pc = 16'h0;
        halt_req = 1'b0; halt_tid = 1'b0;
`ifdef SCHED_STALL_EN
        stall = 2'b00;
`endif
        // Reset state.
        do_reset();
        chk("rst_fetch_valid", fetch_valid, 32'd0);
        chk("rst_halted", thread_halted, 32'd0);

        // Alternating issue from reset PCs.
        seq_pc = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("alt_tid", fetch_tid, k % 2);
            chk("alt_pc", fetch_pc, seq_pc[k]);
        end

        // Redirect thread 0 when it is due: thread 1 issues, then thread 0 at target.
        cyc(1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 2'b00);
        chk("redir_other_tid", fetch_tid, 32'd1);
        chk("redir_other_pc", fetch_pc, 32'h0005);
        idle();
        chk("redir_target_pc", fetch_pc, 32'h0100);
        chk("redir_target_tid", fetch_tid, 32'd0);

        // Halt thread 1: thread 0 issues every cycle.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("h1_pc", fetch_pc, 2 * (k + 1));
            chk("h1_tid", fetch_tid, 32'd0);
            chk("h1_halted", thread_halted, 32'd2);
            chk("h1_halt", halt, 32'd0);
        end

        // Halt both threads: halt rises after the second request and stays.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
        chk("h0_other_issues", fetch_tid, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 2'b00);
        chk("hboth_valid", fetch_valid, 32'd0);
        chk("hboth_halt", halt, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 2'b00);
        idle();
        chk("hboth_hold", halt, 32'd1);
        chk("hboth_pc_hold", fetch_pc, 32'h0001);

        // PC wrap on both threads.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 2'b00);
        idle();
        chk("wrap0_a", fetch_pc, 32'hFFFE);
        idle();
        idle();
        chk("wrap0_b", fetch_pc, 32'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 2'b00);
        chk("redir1_other_tid", fetch_tid, 32'd0);
        idle();
        chk("wrap1_a", fetch_pc, 32'hFFFF);
        idle();
        idle();
        chk("wrap1_b", fetch_pc, 32'h0001);

        // Same-thread halt and redirect: halt wins.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 2'b00);
        idle();
        idle();
        chk("hr_same_tid", fetch_tid, 32'd0);

        // Reset with every other input active.
        idle();
        cyc(1'b1, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b1, 2'b11);
        chk("midreset_pc", fetch_pc, 32'd0);
        chk("midreset_halted", thread_halted, 32'd0);

`ifdef SCHED_STALL_EN
        // Stall both threads, then release.
        do_reset();
        idle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b11);
            chk("stall_valid", fetch_valid, 32'd0);
            chk("stall_pc_hold", fetch_pc, 32'h0001);
        end
        idle();
        chk("stall_resume_tid", fetch_tid, 32'd0);
        chk("stall_resume_pc", fetch_pc, 32'h0002);
        idle();
        chk("stall_resume_pc1", fetch_pc, 32'h0003);
`endif

        // Random traffic with occasional reset.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 79) == 0,
                $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)),
                16'($urandom),
                $urandom_range(0, 49) == 0,
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
